// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
//   Shared definitions for the ALU control slice: the ALUOp class
//   encoding from main control, the 4-bit ALU operation select, the
//   funct3 values, and a helper that maps funct3 onto the arithmetic
//   and logic operations shared by R-type and I-type instructions.
package alu_ctrl_pkg;

  // Operation class driven by the main control unit. 101-111 are unused.
  typedef enum logic [2:0] {
    ALUOP_R     = 3'b000,
    ALUOP_BR    = 3'b001,
    ALUOP_MEM   = 3'b010,
    ALUOP_IMM   = 3'b011,
    ALUOP_UPPER = 3'b100
  } alu_op_e;

  // ALU operation select. 1010-1111 are never produced.
  typedef enum logic [3:0] {
    SEL_ADD  = 4'b0000,
    SEL_SUB  = 4'b0001,
    SEL_SLL  = 4'b0010,
    SEL_SLT  = 4'b0011,
    SEL_SLTU = 4'b0100,
    SEL_XOR  = 4'b0101,
    SEL_SRL  = 4'b0110,
    SEL_SRA  = 4'b0111,
    SEL_OR   = 4'b1000,
    SEL_AND  = 4'b1001
  } alu_sel_e;

  // funct3 values for the OP / OP-IMM opcodes
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // funct3 values for the BRANCH opcode
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Maps funct3 to an ALU select. alt_sub selects SUB over ADD for
  // f3=000 and alt_sra selects SRA over SRL for f3=101; the caller
  // decides which of those bits are meaningful for its instruction class.
  function automatic alu_sel_e arith_sel(input logic [2:0] f3,
                                         input logic       alt_sub,
                                         input logic       alt_sra);
    alu_sel_e sel;
    sel = SEL_ADD;
    case (f3)
      F3_ADD_SUB: sel = alt_sub ? SEL_SUB : SEL_ADD;
      F3_SLL:     sel = SEL_SLL;
      F3_SLT:     sel = SEL_SLT;
      F3_SLTU:    sel = SEL_SLTU;
      F3_XOR:     sel = SEL_XOR;
      F3_SRL_SRA: sel = alt_sra ? SEL_SRA : SEL_SRL;
      F3_OR:      sel = SEL_OR;
      F3_AND:     sel = SEL_AND;
      default:    sel = SEL_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode
//   Purely combinational ALU control decoder.
//   Ports:
//     alu_op           in  3  operation class from main control
//     instruction_bits in  4  {instr[30], funct3}
//     alu_sel          out 4  ALU operation select
//     illegal          out 1  ALUOp/funct3 combination is undefined
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [3:0] instruction_bits,
  output logic [3:0] alu_sel,
  output logic       illegal
);

  logic [2:0] f3;
  logic       b3;

  assign f3 = instruction_bits[2:0];
  assign b3 = instruction_bits[3];

  always_comb begin
    alu_sel = SEL_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_R: begin
        alu_sel = arith_sel(f3, b3, b3);
      end
      ALUOP_BR: begin
        // Branches compare via subtraction or set-less-than; f3 010/011
        // are not branch encodings, so flag them but still drive SUB.
        case (f3)
          F3_BEQ, F3_BNE:   alu_sel = SEL_SUB;
          F3_BLT, F3_BGE:   alu_sel = SEL_SLT;
          F3_BLTU, F3_BGEU: alu_sel = SEL_SLTU;
          default: begin
            alu_sel = SEL_SUB;
            illegal = 1'b1;
          end
        endcase
      end
      ALUOP_MEM, ALUOP_UPPER: begin
        alu_sel = SEL_ADD;
      end
      ALUOP_IMM: begin
        // instr[30] is an immediate bit for ADDI, so it never selects SUB;
        // for shifts it still distinguishes SRAI from SRLI.
        alu_sel = arith_sel(f3, 1'b0, b3);
      end
      default: begin
        alu_sel = SEL_ADD;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_control.sv
// alu_control
//   ALU control unit between main control and the ALU. Provides a
//   zero-latency combinational select plus a registered copy and a
//   sticky illegal-decode flag.
//   Ports:
//     CLK              in  1  clock, rising edge
//     RST              in  1  asynchronous active-high reset
//     ALUOp            in  3  operation class from main control
//     instruction_bits in  4  {instr[30], funct3}
//     en               in  1  load enable for the registered outputs
//     ALU_control      out 4  combinational ALU select
//     illegal          out 1  combinational illegal-combination flag
//     ALU_control_q    out 4  ALU_control registered when en=1
//     illegal_sticky   out 1  latches any illegal decode seen with en=1
module alu_control
  import alu_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] ALUOp,
  input  logic [3:0] instruction_bits,
  input  logic       en,
  output logic [3:0] ALU_control,
  output logic       illegal,
  output logic [3:0] ALU_control_q,
  output logic       illegal_sticky
);

  logic [3:0] alu_sel_reg;
  logic       illegal_sticky_reg;

  alu_ctrl_decode u_decode (
    .alu_op           (ALUOp),
    .instruction_bits (instruction_bits),
    .alu_sel          (ALU_control),
    .illegal          (illegal)
  );

  // Sticky flag only accumulates on enabled edges, so an illegal decode
  // that is never consumed downstream does not get recorded.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      alu_sel_reg        <= SEL_ADD;
      illegal_sticky_reg <= 1'b0;
    end else if (en) begin
      alu_sel_reg        <= ALU_control;
      illegal_sticky_reg <= illegal_sticky_reg | illegal;
    end
  end

  assign ALU_control_q  = alu_sel_reg;
  assign illegal_sticky = illegal_sticky_reg;

endmodule

// File: tb/tb_alu_control.sv
module tb_alu_control;

  logic       CLK;
  logic       RST;
  logic [2:0] ALUOp;
  logic [3:0] instruction_bits;
  logic       en;
  logic [3:0] ALU_control;
  logic       illegal;
  logic [3:0] ALU_control_q;
  logic       illegal_sticky;

  int tests_run;
  int tests_failed;

  alu_control dut (
    .CLK              (CLK),
    .RST              (RST),
    .ALUOp            (ALUOp),
    .instruction_bits (instruction_bits),
    .en               (en),
    .ALU_control      (ALU_control),
    .illegal          (illegal),
    .ALU_control_q    (ALU_control_q),
    .illegal_sticky   (illegal_sticky)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference decode, written from the opcode tables: returns {illegal, select}.
  function automatic logic [4:0] ref_decode(input logic [2:0] op, input logic [3:0] bits);
    logic [2:0] f;
    logic       b;
    logic [3:0] s;
    logic       ill;
    f   = bits[2:0];
    b   = bits[3];
    s   = 4'd0;
    ill = 1'b0;
    if (op == 3'd0 || op == 3'd3) begin
      case (f)
        3'd0: s = (op == 3'd0 && b) ? 4'd1 : 4'd0;
        3'd1: s = 4'd2;
        3'd2: s = 4'd3;
        3'd3: s = 4'd4;
        3'd4: s = 4'd5;
        3'd5: s = b ? 4'd7 : 4'd6;
        3'd6: s = 4'd8;
        default: s = 4'd9;
      endcase
    end else if (op == 3'd1) begin
      if (f == 3'd0 || f == 3'd1)      s = 4'd1;
      else if (f == 3'd4 || f == 3'd5) s = 4'd3;
      else if (f == 3'd6 || f == 3'd7) s = 4'd4;
      else begin
        s   = 4'd1;
        ill = 1'b1;
      end
    end else if (op == 3'd2 || op == 3'd4) begin
      s = 4'd0;
    end else begin
      s   = 4'd0;
      ill = 1'b1;
    end
    return {ill, s};
  endfunction

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [2:0] op, input logic [3:0] bits);
    ALUOp            = op;
    instruction_bits = bits;
    #1;
  endtask

  initial begin
    logic [4:0] exp_v;
    tests_run        = 0;
    tests_failed     = 0;
    RST              = 1'b1;
    en               = 1'b0;
    ALUOp            = 3'd0;
    instruction_bits = 4'd0;

    repeat (2) @(posedge CLK);
    #1;
    chk("reset_q", {1'b0, ALU_control_q}, 5'b00000);
    chk("reset_sticky", {4'b0000, illegal_sticky}, 5'b00000);

    // Exhaustive combinational sweep
    for (int op = 0; op < 8; op++) begin
      for (int b = 0; b < 16; b++) begin
        apply(op[2:0], b[3:0]);
        exp_v = ref_decode(op[2:0], b[3:0]);
        chk($sformatf("sweep op=%0d bits=%0d", op, b), {illegal, ALU_control}, exp_v);
      end
    end

    // Spot checks with hand-computed values: {illegal, select}
    apply(3'b000, 4'b1000); chk("R_sub",   {illegal, ALU_control}, 5'b0_0001);
    apply(3'b000, 4'b0000); chk("R_add",   {illegal, ALU_control}, 5'b0_0000);
    apply(3'b000, 4'b1101); chk("R_sra",   {illegal, ALU_control}, 5'b0_0111);
    apply(3'b000, 4'b1110); chk("R_or",    {illegal, ALU_control}, 5'b0_1000);
    apply(3'b011, 4'b1000); chk("I_addi",  {illegal, ALU_control}, 5'b0_0000);
    apply(3'b011, 4'b1101); chk("I_srai",  {illegal, ALU_control}, 5'b0_0111);
    apply(3'b011, 4'b0101); chk("I_srli",  {illegal, ALU_control}, 5'b0_0110);
    apply(3'b001, 4'b0001); chk("BR_bne",  {illegal, ALU_control}, 5'b0_0001);
    apply(3'b001, 4'b0110); chk("BR_bltu", {illegal, ALU_control}, 5'b0_0100);
    apply(3'b001, 4'b0010); chk("BR_ill",  {illegal, ALU_control}, 5'b1_0001);
    apply(3'b111, 4'b0000); chk("op7_ill", {illegal, ALU_control}, 5'b1_0000);

    // Registered path: release reset on a falling edge, load R/AND
    @(negedge CLK);
    RST = 1'b0;
    en  = 1'b1;
    ALUOp = 3'b000; instruction_bits = 4'b0111;
    @(posedge CLK); #1;
    chk("q_load_and", {illegal_sticky, ALU_control_q}, 5'b0_1001);

    // en=0 holds
    @(negedge CLK);
    en = 1'b0;
    instruction_bits = 4'b1000;
    @(posedge CLK); #1;
    chk("q_hold", {illegal_sticky, ALU_control_q}, 5'b0_1001);

    // illegal with en=0 must not set sticky
    @(negedge CLK);
    ALUOp = 3'b110; instruction_bits = 4'b0000;
    @(posedge CLK); #1;
    chk("sticky_en0", {illegal_sticky, ALU_control_q}, 5'b0_1001);

    // enabled illegal sets sticky and loads ADD
    @(negedge CLK);
    en = 1'b1;
    @(posedge CLK); #1;
    chk("sticky_set", {illegal_sticky, ALU_control_q}, 5'b1_0000);

    // legal input afterwards: sticky remains
    @(negedge CLK);
    ALUOp = 3'b000; instruction_bits = 4'b0110;
    @(posedge CLK); #1;
    chk("sticky_keep", {illegal_sticky, ALU_control_q}, 5'b1_1000);

    // Asynchronous reset between edges
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst", {illegal_sticky, ALU_control_q}, 5'b0_0000);

    // Reset held across an enabled illegal edge overrides the load
    ALUOp = 3'b101;
    @(posedge CLK); #1;
    chk("rst_override", {illegal_sticky, ALU_control_q}, 5'b0_0000);

    // First load after reset release
    @(negedge CLK);
    RST = 1'b0;
    ALUOp = 3'b000; instruction_bits = 4'b0100;
    @(posedge CLK); #1;
    chk("post_rst_load", {illegal_sticky, ALU_control_q}, 5'b0_0101);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
